// File: rtl/bp_train_sched_pkg.sv
// Shared definitions for the branch-predictor training scheduler:
// table init code, scheduler FSM encodings and training-entry layout.
package bp_train_sched_pkg;

    // Value every pattern-table counter holds after an init write (weakly not-taken).
    localparam logic [1:0] WNT_INIT = 2'b01;

    // Scheduler FSM: sweeping the tables, or serving fetch and training traffic.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } schedState_t;

    // Training entry layout: {idx[N-1:0], taken}; taken sits in bit 0.
    localparam int ENTRY_TAKEN_BIT = 0;
    localparam int ENTRY_IDX_LSB   = 1;

    // Width of one packed training entry for a given table index width.
    function automatic int entryWidth(input int idxWidth);
        return idxWidth + 1;
    endfunction

endpackage

// File: rtl/bp_train_fifo.sv
// Small register FIFO holding pending training writes for the pattern tables.
// A push on a full FIFO is only accepted together with a pop in the same cycle.
module bp_train_fifo
    import bp_train_sched_pkg::*;
#(
    parameter int N     = 12,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [entryWidth(N)-1:0] i_data,
    output logic [entryWidth(N)-1:0] o_head,
    output logic [PTR_W:0]           o_count,
    output logic                     o_full
);

    localparam int             EW         = entryWidth(N);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [EW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;

    logic w_doPush;
    logic w_doPop;

    // Qualify requests so the occupancy can never over- or underflow.
    always_comb begin
        w_doPop  = i_pop && (r_count != '0);
        w_doPush = i_push && ((r_count != FULL_COUNT) || w_doPop);
    end

    // Pointer and occupancy bookkeeping; clear empties the FIFO at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_doPop && !w_doPush) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Entry storage; contents need no reset because the count gates them.
    always_ff @(posedge clk) begin
        if (w_doPush && !i_clear) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_COUNT);

endmodule

// File: rtl/bp_train_sched.sv
// Training-update scheduler for the single-ported branch pattern tables.
// Sweeps every entry to weakly-not-taken after reset or flush, then shares
// the table port between fetch lookups and queued training writes.
module bp_train_sched
    import bp_train_sched_pkg::*;
#(
    parameter int N     = 12,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_tables,
    input  logic             f_rd_req,
    output logic             f_stall,
    input  logic             e_train_valid,
    input  logic [31:0]      e_pc,
    input  logic [N-1:0]     e_train_ghr_snapshot,
    input  logic             e_actual_taken,
    output logic             tbl_wr_en,
    output logic [N-1:0]     tbl_wr_idx,
    output logic             tbl_wr_init,
    output logic             tbl_wr_taken,
    output logic             init_done,
    output logic [PTR_W:0]   fifo_count,
    output logic             drop_evt
);

    localparam int           EW      = entryWidth(N);
    localparam logic [N-1:0] IDX_ONE = N'(1);

    schedState_t r_state;
    logic [N-1:0] r_sweepIdx;
    logic         r_initDone;
    logic         r_drop;

    logic [EW-1:0]  w_pushEntry;
    logic [EW-1:0]  w_head;
    logic [PTR_W:0] w_count;
    logic           w_full;
    logic           w_inRun;
    logic           w_fifoWrite;
    logic           w_push;
    logic           w_pop;
    logic           w_unusedPc;

    // Only the word-aligned low PC bits feed the hashed index.
    assign w_unusedPc = ^{e_pc[31:N+2], e_pc[1:0]};

    // Build the queued entry: PC-hashed index plus resolved direction.
    always_comb begin
        w_pushEntry = '0;
        w_pushEntry[ENTRY_IDX_LSB +: N] = e_pc[N+1:2] ^ e_train_ghr_snapshot;
        w_pushEntry[ENTRY_TAKEN_BIT]    = e_actual_taken;
    end

    // Port arbitration: a full FIFO wins over fetch, otherwise fetch wins
    // and training drains only on idle fetch cycles. Flush blocks everything.
    always_comb begin
        w_inRun     = (r_state == ST_RUN);
        w_fifoWrite = 1'b0;
        if (w_inRun && !flush_tables) begin
            if (w_full || (!f_rd_req && (w_count != '0))) begin
                w_fifoWrite = 1'b1;
            end
        end
        w_pop  = w_fifoWrite;
        w_push = w_inRun && !flush_tables && e_train_valid && (!w_full || w_pop);
    end

    // Table-port outputs come straight from state and FIFO head so the table
    // samples the write on the same edge that pops the entry.
    always_comb begin
        f_stall      = !w_inRun || (w_full && f_rd_req);
        tbl_wr_en    = !rst && !flush_tables && (!w_inRun || w_fifoWrite);
        tbl_wr_init  = !rst && !flush_tables && !w_inRun;
        tbl_wr_idx   = '0;
        tbl_wr_taken = WNT_INIT[1];
        if (!w_inRun) begin
            tbl_wr_idx = r_sweepIdx;
        end else if (w_fifoWrite) begin
            tbl_wr_idx   = w_head[ENTRY_IDX_LSB +: N];
            tbl_wr_taken = w_head[ENTRY_TAKEN_BIT];
        end
    end

    // Scheduler FSM: sweep counter, init-done flag and the drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_sweepIdx <= '0;
            r_initDone <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_drop <= e_train_valid && !w_push;
            if (flush_tables) begin
                r_state    <= ST_INIT;
                r_sweepIdx <= '0;
                r_initDone <= 1'b0;
            end else if (r_state == ST_INIT) begin
                r_sweepIdx <= r_sweepIdx + IDX_ONE;
                if (r_sweepIdx == '1) begin
                    r_state    <= ST_RUN;
                    r_initDone <= 1'b1;
                end
            end
        end
    end

    bp_train_fifo #(
        .N     (N),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (flush_tables),
        .i_data  (w_pushEntry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full)
    );

    assign init_done  = r_initDone;
    assign fifo_count = w_count;
    assign drop_evt   = r_drop;

endmodule

// File: tb/tb_bp_train_sched.sv
// Directed testbench for bp_train_sched with N=4, DEPTH=4.
// Expected values are hand-computed from the scheduler's intended behaviour.
module tb_bp_train_sched;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_tables;
    logic             f_rd_req;
    logic             f_stall;
    logic             e_train_valid;
    logic [31:0]      e_pc;
    logic [N-1:0]     e_train_ghr_snapshot;
    logic             e_actual_taken;
    logic             tbl_wr_en;
    logic [N-1:0]     tbl_wr_idx;
    logic             tbl_wr_init;
    logic             tbl_wr_taken;
    logic             init_done;
    logic [PTR_W:0]   fifo_count;
    logic             drop_evt;

    int testsRun    = 0;
    int testsFailed = 0;

    bp_train_sched #(
        .N     (N),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush_tables         (flush_tables),
        .f_rd_req             (f_rd_req),
        .f_stall              (f_stall),
        .e_train_valid        (e_train_valid),
        .e_pc                 (e_pc),
        .e_train_ghr_snapshot (e_train_ghr_snapshot),
        .e_actual_taken       (e_actual_taken),
        .tbl_wr_en            (tbl_wr_en),
        .tbl_wr_idx           (tbl_wr_idx),
        .tbl_wr_init          (tbl_wr_init),
        .tbl_wr_taken         (tbl_wr_taken),
        .init_done            (init_done),
        .fifo_count           (fifo_count),
        .drop_evt             (drop_evt)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive all non-reset inputs at once.
    task automatic applyStimulus(input logic flush, input logic rdReq, input logic valid,
                                 input logic [31:0] pc, input logic [N-1:0] ghr, input logic taken);
        flush_tables         = flush;
        f_rd_req             = rdReq;
        e_train_valid        = valid;
        e_pc                 = pc;
        e_train_ghr_snapshot = ghr;
        e_actual_taken       = taken;
        #1;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Check the full table-port view in one call.
    task automatic checkPort(input string tag, input logic en, input logic init,
                             input logic [N-1:0] idx, input logic taken, input logic stall);
        checkOutput({tag, ".wr_en"}, 32'(tbl_wr_en), 32'(en));
        checkOutput({tag, ".wr_init"}, 32'(tbl_wr_init), 32'(init));
        if (en) begin
            checkOutput({tag, ".wr_idx"}, 32'(tbl_wr_idx), 32'(idx));
            checkOutput({tag, ".wr_taken"}, 32'(tbl_wr_taken), 32'(taken));
        end
        checkOutput({tag, ".f_stall"}, 32'(f_stall), 32'(stall));
    endtask

    // Check every output against its reset value.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".f_stall"}, 32'(f_stall), 32'd1);
        checkOutput({tag, ".wr_en"}, 32'(tbl_wr_en), 32'd0);
        checkOutput({tag, ".wr_idx"}, 32'(tbl_wr_idx), 32'd0);
        checkOutput({tag, ".wr_init"}, 32'(tbl_wr_init), 32'd0);
        checkOutput({tag, ".wr_taken"}, 32'(tbl_wr_taken), 32'd0);
        checkOutput({tag, ".init_done"}, 32'(init_done), 32'd0);
        checkOutput({tag, ".count"}, 32'(fifo_count), 32'd0);
        checkOutput({tag, ".drop"}, 32'(drop_evt), 32'd0);
    endtask

    logic [31:0] fillPc    [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
    logic        fillTaken [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0);
        stepCycle();
        stepCycle();
        checkResetValues("reset");

        // Sweep after reset release; an event at idx 5 must be dropped.
        rst = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, (i == 5), 32'h14, 4'h3, 1'b1);
            checkPort($sformatf("sweep%0d", i), 1'b1, 1'b1, N'(i), 1'b0, 1'b1);
            checkOutput($sformatf("sweep%0d.init_done", i), 32'(init_done), 32'd0);
            stepCycle();
            if (i == 5) begin
                checkOutput("initEvt.drop", 32'(drop_evt), 32'd1);
                checkOutput("initEvt.count", 32'(fifo_count), 32'd0);
            end
            if (i == 6) begin
                checkOutput("initEvt.dropPulse", 32'(drop_evt), 32'd0);
            end
        end
        checkOutput("run.init_done", 32'(init_done), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, '0, 1'b0);
        checkPort("run.fetch", 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Single event with an idle fetch port: written the next cycle.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h14, 4'b0011, 1'b1);
        checkPort("evt1.pre", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0);
        checkOutput("evt1.count", 32'(fifo_count), 32'd1);
        checkPort("evt1.write", 1'b1, 1'b0, 4'b0110, 1'b1, 1'b0);
        stepCycle();
        checkOutput("evt1.countAfter", 32'(fifo_count), 32'd0);
        checkPort("evt1.idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Fetch holds the port while four events fill the FIFO.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, fillPc[i], 4'h0, fillTaken[i]);
            checkPort($sformatf("fill%0d", i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
            stepCycle();
        end
        checkOutput("fill.count", 32'(fifo_count), 32'd4);

        // Full FIFO overrides fetch; a simultaneous fifth event is accepted.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h14, 4'h0, 1'b1);
        checkPort("full.w1", 1'b1, 1'b0, 4'h1, 1'b1, 1'b1);
        stepCycle();
        checkOutput("full.count", 32'(fifo_count), 32'd4);
        checkOutput("full.drop", 32'(drop_evt), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, '0, 1'b0);
        checkPort("full.w2", 1'b1, 1'b0, 4'h2, 1'b0, 1'b1);
        stepCycle();
        checkOutput("drain.count3", 32'(fifo_count), 32'd3);
        checkPort("drain.fetchWins", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0);
        checkPort("drain.w3", 1'b1, 1'b0, 4'h3, 1'b1, 1'b0);
        stepCycle();
        checkPort("drain.w4", 1'b1, 1'b0, 4'h4, 1'b0, 1'b0);
        stepCycle();
        checkPort("drain.w5", 1'b1, 1'b0, 4'h5, 1'b1, 1'b0);
        stepCycle();
        checkOutput("drain.count0", 32'(fifo_count), 32'd0);

        // Queue three entries, then flush with an event in the same cycle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'h1C + 32'(i * 4), 4'h0, 1'b1);
            stepCycle();
        end
        checkOutput("flush.preCount", 32'(fifo_count), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h4, 4'h0, 1'b1);
        checkOutput("flush.noWrite", 32'(tbl_wr_en), 32'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0);
        checkOutput("flush.count", 32'(fifo_count), 32'd0);
        checkOutput("flush.init_done", 32'(init_done), 32'd0);
        checkOutput("flush.drop", 32'(drop_evt), 32'd1);
        for (int i = 0; i < 9; i++) begin
            checkPort($sformatf("resweep%0d", i), 1'b1, 1'b1, N'(i), 1'b0, 1'b1);
            stepCycle();
        end
        checkPort("resweep9", 1'b1, 1'b1, 4'd9, 1'b0, 1'b1);

        // Asynchronous reset mid-sweep at idx 9, held across one edge.
        rst = 1'b1;
        #1;
        checkResetValues("midRst");
        stepCycle();
        rst = 1'b0;
        #1;
        checkPort("postRst0", 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        stepCycle();
        checkPort("postRst1", 1'b1, 1'b1, 4'd1, 1'b0, 1'b1);
        checkOutput("postRst.init_done", 32'(init_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
